// File: rtl/fp754_pkg.sv
// Shared types and constants for the single-precision add/sub datapath.
package fp754_pkg;

    // Sequencer states of the normalize/round stage
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Packed single-precision word
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/norm_round754_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input reports 24.
module lzc24 (
    input  logic [23:0] i_val,
    output logic [4:0]  o_cnt
);

    // Scan upward so the highest set bit has the final say
    always_comb begin
        o_cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_val[i]) o_cnt = 5'(23 - i);
        end
    end

endmodule

// File: rtl/norm_round754.sv
// Post-add normalize + round-to-nearest-even stage for single precision.
// Optional macro NORM754_LZC_EN: single-cycle left normalization via
// leading-zero count and barrel shift; default is one bit per cycle.
module norm_round754
    import fp754_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sign_i,
    input  logic [EXP_W-1:0]       exp_i,
    input  logic [MAN_W+1:0]       mant_i,
    input  logic [2:0]             grs_i,
    input  logic                   bypass_i,
    input  logic [EXP_W+MAN_W:0]   bypass_val_i,
    output logic [EXP_W+MAN_W:0]   R,
    output logic                   ready,
    output logic                   busy
);

    localparam int MW = MAN_W + 2;   // carry + hidden + fraction
    localparam int EW = EXP_W + 1;   // spare bit exposes over/underflow
    localparam logic [EW-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};

    state_t            r_state;
    logic              r_sign;
    logic [EW-1:0]     r_exp;
    logic [MW-1:0]     r_mant;
    logic              r_g, r_r, r_s;

    logic [EXP_W+MAN_W:0] w_inf, w_zero;
    logic [EW-1:0]        w_rsexp;
    logic                 w_up;
    logic [MAN_W+1:0]     w_rsum;
    logic [EW-1:0]        w_rexp;
    logic [MAN_W-1:0]     w_rfrac;
    logic [MW-1:0]        w_lmant;
    logic [EW-1:0]        w_lexp;
    logic                 w_lg, w_lr, w_luf;

    assign w_inf   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_zero  = {r_sign, {(EXP_W+MAN_W){1'b0}}};
    assign w_rsexp = r_exp + EW'(1);

    // RNE increment; a carry out of the 24-bit significand bumps the exponent
    assign w_up    = r_g & (r_r | r_s | r_mant[0]);
    assign w_rsum  = {1'b0, r_mant[MAN_W:0]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_rexp  = r_exp + {{EXP_W{1'b0}}, w_rsum[MAN_W+1]};
    assign w_rfrac = w_rsum[MAN_W+1] ? '0 : w_rsum[MAN_W-1:0];

`ifdef NORM754_LZC_EN
    localparam state_t LSH_NEXT = ROUND;
    logic [4:0]       w_lzc;
    logic [MAN_W+2:0] w_wide;

    lzc24 u_lzc (
        .i_val (r_mant[MAN_W:0]),
        .o_cnt (w_lzc)
    );

    // Guard and round ride along the barrel shift; zeros fill below them
    assign w_wide  = {r_mant[MAN_W:0], r_g, r_r} << w_lzc;
    assign w_lmant = {1'b0, w_wide[MAN_W+2:2]};
    assign w_lg    = w_wide[1];
    assign w_lr    = w_wide[0];
    assign w_lexp  = r_exp - {{(EW-5){1'b0}}, w_lzc};
    assign w_luf   = (r_exp <= {{(EW-5){1'b0}}, w_lzc});
`else
    localparam state_t LSH_NEXT = NORM;

    // One-bit left step: guard enters the LSB, round moves into guard
    assign w_lmant = {1'b0, r_mant[MAN_W-1:0], r_g};
    assign w_lg    = r_r;
    assign w_lr    = 1'b0;
    assign w_lexp  = r_exp - EW'(1);
    assign w_luf   = (w_lexp == '0);
`endif

    // Sequencer: latch, normalize, round, then pulse ready for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_g     <= 1'b0;
            r_r     <= 1'b0;
            r_s     <= 1'b0;
            R       <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign              <= sign_i;
                        r_exp               <= {1'b0, exp_i};
                        r_mant              <= mant_i;
                        {r_g, r_r, r_s}     <= grs_i;
                        busy                <= 1'b1;
                        if (bypass_i) begin
                            R       <= bypass_val_i;
                            r_state <= DONE;
                        end else if (mant_i == '0 && grs_i == 3'b000) begin
                            R       <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_exp == '0) begin
                        // zero exponent with a live mantissa would be subnormal
                        R       <= w_zero;
                        r_state <= DONE;
                    end else if (r_mant[MW-1]) begin
                        r_mant  <= r_mant >> 1;
                        r_g     <= r_mant[0];
                        r_r     <= r_g;
                        r_s     <= r_r | r_s;
                        r_exp   <= w_rsexp;
                        if (w_rsexp >= EXP_INF) begin
                            R       <= w_inf;
                            r_state <= DONE;
                        end else begin
                            r_state <= ROUND;
                        end
                    end else if (!r_mant[MW-2]) begin
                        if (w_luf) begin
                            R       <= w_zero;
                            r_state <= DONE;
                        end else begin
                            r_mant  <= w_lmant;
                            r_exp   <= w_lexp;
                            r_g     <= w_lg;
                            r_r     <= w_lr;
                            r_state <= LSH_NEXT;
                        end
                    end else begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_rexp >= EXP_INF) R <= w_inf;
                    else                   R <= {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
                    r_state <= DONE;
                end
                DONE: begin
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_round754.sv
// Scoreboard bench for norm_round754: directed vectors push expected
// results; a negedge monitor pops and compares on every ready pulse.
module tb_norm_round754;
    import fp754_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = '0;
    logic [24:0] mant_i = '0;
    logic [2:0]  grs_i = '0;
    logic        bypass_i = 1'b0;
    logic [31:0] bypass_val_i = '0;
    logic [31:0] R;
    logic        ready, busy;

    norm_round754 dut (
        .clk(clk), .reset(reset), .start(start), .sign_i(sign_i),
        .exp_i(exp_i), .mant_i(mant_i), .grs_i(grs_i), .bypass_i(bypass_i),
        .bypass_val_i(bypass_val_i), .R(R), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        int          e_rdy;   // expected cycle of ready, -1 = latency not checked
        int          dl;      // last cycle ready may still appear
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

`ifdef NORM754_LZC_EN
    localparam int LAT_DEEP = 3;
    localparam int LAT_ONE  = 3;
`else
    localparam int LAT_DEEP = 26;
    localparam int LAT_ONE  = 4;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    // Monitor: compare each ready pulse against the oldest expectation
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected 0 at cycle %0d", cyc);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.nm, "_R"}, R, m_e.r);
                if (m_e.e_rdy >= 0) chk({m_e.nm, "_latency"}, cyc, m_e.e_rdy);
            end
        end else if (sb.size() != 0 && cyc > sb[0].dl) begin
            m_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready by cycle %0d expected by %0d", m_e.nm, cyc, m_e.dl);
        end
    end

    // Issue one request at a negedge; optionally record the expected result
    task automatic issue(input string nm, input logic s, input logic [7:0] e,
                         input logic [24:0] m, input logic [2:0] g, input logic b,
                         input logic [31:0] bv, input logic [31:0] exp_r,
                         input int lat, input bit push);
        int n;
        exp_t x;
        n = 0;
        while ((busy !== 1'b0 || ready !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_idle_wait: got busy=%b expected 0", nm, busy);
        end
        sign_i = s; exp_i = e; mant_i = m; grs_i = g;
        bypass_i = b; bypass_val_i = bv; start = 1'b1;
        if (push) begin
            x.r     = exp_r;
            x.e_rdy = (lat >= 0) ? cyc + 1 + lat : -1;
            x.dl    = cyc + 1 + ((lat >= 0) ? lat : 60);
            x.nm    = nm;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
        bypass_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", nm, sb.size());
        end
    endtask

    localparam logic [31:0] DEEP_R = fp32_t'{sign: 1'b0, exp: 8'd107, frac: 23'd0};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_R", R, 32'h0);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        //     name          s  exp      mant          grs   byp  bval     expected      latency
        issue("carry",      0, 8'd127, 25'h1800000, 3'b000, 0, 32'h0, 32'h40400000, 3,        1);
        issue("deep",       0, 8'd130, 25'h0000001, 3'b000, 0, 32'h0, DEEP_R,       LAT_DEEP, 1);
        issue("rne_up",     0, 8'd127, 25'h0800001, 3'b100, 0, 32'h0, 32'h3F800002, 3,        1);
        issue("rne_tie",    0, 8'd127, 25'h0800000, 3'b100, 0, 32'h0, 32'h3F800000, 3,        1);
        issue("rne_stk",    0, 8'd127, 25'h0800000, 3'b101, 0, 32'h0, 32'h3F800001, 3,        1);
        issue("rnd_ovf",    0, 8'd254, 25'h0FFFFFF, 3'b110, 0, 32'h0, POS_INF,      3,        1);
        issue("uflow",      1, 8'd2,   25'h0000100, 3'b000, 0, 32'h0, 32'h80000000, -1,       1);
        issue("bypass",     0, 8'd0,   25'h0,       3'b000, 1, QNAN,  QNAN,         1,        1);
        issue("zero",       1, 8'd90,  25'h0,       3'b000, 0, 32'h0, 32'h00000000, 1,        1);
        issue("neg_norm",   1, 8'd128, 25'h0C00000, 3'b000, 0, 32'h0, 32'hC0400000, 3,        1);
        issue("shift_g",    0, 8'd127, 25'h0400000, 3'b100, 0, 32'h0, 32'h3F000001, LAT_ONE,  1);
        issue("exp0_in",    0, 8'd0,   25'h0800000, 3'b000, 0, 32'h0, 32'h00000000, -1,       1);
        issue("rshift_inf", 1, 8'd254, 25'h1000000, 3'b000, 0, 32'h0, 32'hFF800000, -1,       1);
        drain("directed");

        // start while busy must be dropped: only the deep result appears
        issue("busy_ign", 0, 8'd130, 25'h0000001, 3'b000, 0, 32'h0, DEEP_R, LAT_DEEP, 1);
        chk("busy_mid", {31'b0, busy}, 32'h1);
        start = 1'b1; bypass_i = 1'b1; bypass_val_i = QNAN;
        @(negedge clk);
        start = 1'b0; bypass_i = 1'b0;
        drain("busy_ign");
        repeat (5) @(negedge clk);

        // leave a nonzero R so the abort visibly clears it
        issue("pre_abort", 0, 8'd127, 25'h1800000, 3'b000, 0, 32'h0, 32'h40400000, 3, 1);
        drain("pre_abort");
        issue("abort", 0, 8'd130, 25'h0000001, 3'b000, 0, 32'h0, 32'h0, -1, 0);
        chk("abort_busy", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("abort_R", R, 32'h0);
        chk("abort_busy_clr", {31'b0, busy}, 32'h0);
        chk("abort_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        issue("after_rst", 0, 8'd127, 25'h0800001, 3'b100, 0, 32'h0, 32'h3F800002, 3, 1);
        drain("after_rst");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norm_round754.md
Name: norm_round754

Overview:
- Post-add normalization and rounding stage for the single-precision add/sub datapath.
- Sits directly downstream of the add/sub FSM and consumes its raw result: sign, aligned exponent, 25-bit mantissa sum (carry + hidden + 23 fraction) and guard/round/sticky bits.
- Produces a packed IEEE-754 word with round-to-nearest-even (RNE), overflow to ±inf and underflow flushed to ±0.
- Special operands (NaN/inf/zero operand) are resolved upstream and passed through a bypass path.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width. The internal mantissa is MAN_W+2 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sign_i  in  1  result sign.
- exp_i  in  8  common exponent after alignment.
- mant_i  in  25  unnormalized sum; bit24 = carry, bit23 = hidden.
- grs_i  in  3  guard/round/sticky from alignment shift.
- bypass_i  in  1  upstream resolved a special case.
- bypass_val_i  in  32  packed special result.
- R  out  32  packed result; held until the next result.
- ready  out  1  one-cycle pulse when R is valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, low): state=IDLE, R=0, ready=0, busy=0, all internal registers cleared. Reset mid-operation aborts the operation and produces no ready pulse.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - On start=1, latch all inputs.
  - If bypass_i: next R=bypass_val_i, go to DONE.
  - Else if mant_i==0 and grs_i==0 (exact cancellation): next R=32'h00000000 (+0), go to DONE.
  - Else go to NORM.
  - start while busy is ignored; no queueing.
- NORM, at most one action per cycle:
  - Right shift, if mant[24]=1: mant>>=1; g<=mant[0], r<=g, s<=r|s; exp+=1. If the new exp==255, the result is ±inf ({sign,8'hFF,0}): go to DONE. Otherwise go to ROUND.
  - Left shift, else if mant[23]=0: mant<=(mant<<1)|g; g<=r; r<=0; s unchanged; exp-=1. If exp reaches 0 before mant[23]=1, flush to {sign,31'b0} and go to DONE. Stay in NORM.
  - Normalized, else (mant[23]=1): go to ROUND.
  - Left-shift count is 0..23 cycles.
- ROUND (RNE): up = g & (r | s | mant[0]).
  - mant24 = mant[23:0] + up.
  - If it carries to 2^24: mant=0x800000 and exp+=1. If exp becomes 255, the result is ±inf.
  - Compute R={sign, exp, mant[22:0]}; go to DONE.
- DONE: ready=1 for exactly one cycle; return to IDLE. start may be accepted on the cycle after DONE.
- Latency is counted as the number of clock edges from the start-sample edge to the edge that raises ready:
  - bypass or zero: 1.
  - already normalized, or carry case: 3.
  - n left shifts: 3+n.
- Width rules: exp is held in 9 bits internally so underflow and overflow are detectable; the output is truncated to 8 bits only after the checks.
- Input exp_i==0 with nonzero mantissa is treated as underflow and flushes to ±0. Subnormal outputs are never produced.

Optional Feature:
- NORM754_LZC_EN.
- Defined: NORM performs the left normalization in a single cycle, using a leading-zero count and a barrel shift (including the g/r bits shifted in). Total latency is fixed at 3 for every non-bypass case. The underflow test is exp <= lzc, which flushes to ±0.
- Undefined: iterative one-bit-per-cycle shifting as described above.
- Results are bit-identical in both modes; only latency differs.

Decomposition:
- Shared package fp754_pkg:
  - state enum type.
  - constants: EXP_MAX=8'hFF, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - packed struct {sign, exp, frac} for the 32-bit word.
- One sub-module, lzc24: combinational 24-bit leading-zero counter, 5-bit output. Instantiated only under NORM754_LZC_EN.

Test Plan:
- Carry case: sign 0, exp 127, mant 0x1800000, grs 000 -> R=0x40400000 (3.0); ready 3 edges after start.
- Deep cancellation: exp 130, mant 0x0000001, grs 000 -> R=0x35800000 (exp 107). Ready after 26 edges, or 3 with NORM754_LZC_EN.
- RNE:
  - exp 127, mant 0x0800001, grs 100 -> R=0x3F800002.
  - mant 0x0800000, grs 100 -> R=0x3F800000 (tie to even).
  - mant 0x0800000, grs 101 -> R=0x3F800001.
- Rounding overflow: exp 254, mant 0x0FFFFFF, grs 110 -> R=0x7F800000, one ready pulse.
- Underflow: sign 1, exp 2, mant 0x0000100 -> R=0x80000000.
- Bypass and reset:
  - bypass_i=1, bypass_val_i=0x7FC00000 -> R=0x7FC00000 after 1 edge.
  - start asserted during busy is ignored.
  - reset pulled low during NORM -> R=0, no ready; the next start completes normally.
